// File: rtl/sdram_aref_pend.sv
// SDRAM auto-refresh engine: interval timer, postponed-refresh queue and
// PRE/AREF command sequencer with optional burst drain on a single grant.
module sdram_aref_pend #(
    parameter int unsigned ADDR_W       = 13,
    parameter int unsigned REF_INTERVAL = 390,
    parameter int unsigned T_RP         = 2,
    parameter int unsigned T_RFC        = 7,
    parameter int unsigned MAX_PEND     = 8,
    parameter int unsigned URGENT_TH    = 6
) (
    input  logic                             sclk,
    input  logic                             s_rst,
    input  logic                             flag_init_end,
    input  logic                             ref_en,
    input  logic                             ref_burst,
    output logic                             ref_req,
    output logic                             ref_urgent,
    output logic                             ref_busy,
    output logic                             flag_ref_end,
    output logic [3:0]                       aref_cmd,
    output logic [ADDR_W-1:0]                sdram_addr,
    output logic [$clog2(MAX_PEND+1)-1:0]    pend_cnt,
    output logic                             pend_ovf
);

    localparam int unsigned PEND_W   = $clog2(MAX_PEND + 1);
    localparam int unsigned CNT_W    = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
    localparam int unsigned WAIT_W   = $clog2(T_RP + T_RFC + 1);
    localparam int unsigned RP_LAST  = (T_RP > 1) ? T_RP - 2 : 0;
    localparam int unsigned RFC_LAST = T_RFC - 2;

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;

    localparam logic [ADDR_W-1:0] ADDR_PRE_ALL = ADDR_W'(1) << 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_WAIT_RP,
        S_AREF,
        S_WAIT_RFC
    } state_t;

    state_t              state, state_nxt;
    logic [WAIT_W-1:0]   wcnt, wcnt_nxt;
    logic [CNT_W-1:0]    icnt, icnt_nxt;
    logic [PEND_W-1:0]   pend_nxt;
    logic                burst_q, burst_nxt;
    logic                ovf_nxt;
    logic                tick;
    logic                aref_now;
    logic                req_nxt, urg_nxt, busy_nxt, end_nxt;
    logic [3:0]          cmd_nxt;
    logic [ADDR_W-1:0]   addr_nxt;

    // State and registered outputs
    always_ff @(posedge sclk) begin
        if (s_rst) begin
            state        <= S_IDLE;
            wcnt         <= '0;
            icnt         <= '0;
            burst_q      <= 1'b0;
            pend_cnt     <= '0;
            pend_ovf     <= 1'b0;
            ref_req      <= 1'b0;
            ref_urgent   <= 1'b0;
            ref_busy     <= 1'b0;
            flag_ref_end <= 1'b0;
            aref_cmd     <= CMD_NOP;
            sdram_addr   <= '0;
        end else begin
            state        <= state_nxt;
            wcnt         <= wcnt_nxt;
            icnt         <= icnt_nxt;
            burst_q      <= burst_nxt;
            pend_cnt     <= pend_nxt;
            pend_ovf     <= ovf_nxt;
            ref_req      <= req_nxt;
            ref_urgent   <= urg_nxt;
            ref_busy     <= busy_nxt;
            flag_ref_end <= end_nxt;
            aref_cmd     <= cmd_nxt;
            sdram_addr   <= addr_nxt;
        end
    end

    // Next state, queue accounting and output lookahead
    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        burst_nxt = burst_q;
        pend_nxt  = pend_cnt;
        ovf_nxt   = pend_ovf;
        tick      = flag_init_end && (icnt == CNT_W'(REF_INTERVAL - 1));
        aref_now  = (state == S_AREF);
        icnt_nxt  = tick ? '0 : icnt + CNT_W'(1);

        // A tick and an AREF in the same cycle cancel out
        if (tick && !aref_now) begin
            if (pend_cnt == PEND_W'(MAX_PEND)) begin
                ovf_nxt = 1'b1;
            end else begin
                pend_nxt = pend_cnt + PEND_W'(1);
            end
        end else if (!tick && aref_now && (pend_cnt != '0)) begin
            pend_nxt = pend_cnt - PEND_W'(1);
        end

        case (state)
            S_IDLE: begin
                if (ref_en && (pend_cnt != '0)) begin
                    state_nxt = S_PRE;
                    burst_nxt = ref_burst;
                end
            end
            S_PRE: begin
                wcnt_nxt  = '0;
                state_nxt = (T_RP == 1) ? S_AREF : S_WAIT_RP;
            end
            S_WAIT_RP: begin
                if (wcnt == WAIT_W'(RP_LAST)) begin
                    state_nxt = S_AREF;
                end else begin
                    wcnt_nxt = wcnt + WAIT_W'(1);
                end
            end
            S_AREF: begin
                wcnt_nxt  = '0;
                state_nxt = S_WAIT_RFC;
            end
            S_WAIT_RFC: begin
                if (wcnt == WAIT_W'(RFC_LAST)) begin
                    state_nxt = (burst_q && (pend_cnt != '0)) ? S_AREF : S_IDLE;
                end else begin
                    wcnt_nxt = wcnt + WAIT_W'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // Init loss aborts everything except the sticky overflow
        if (!flag_init_end) begin
            state_nxt = S_IDLE;
            wcnt_nxt  = '0;
            icnt_nxt  = '0;
            pend_nxt  = '0;
        end

        req_nxt  = (state_nxt == S_IDLE) && (pend_nxt != '0);
        urg_nxt  = (pend_nxt >= PEND_W'(URGENT_TH));
        busy_nxt = (state_nxt != S_IDLE);
        // End pulse coincides with the final WAIT_RFC cycle that returns to IDLE
        end_nxt  = (state_nxt == S_WAIT_RFC) && (wcnt_nxt == WAIT_W'(RFC_LAST)) &&
                   !(burst_nxt && (pend_nxt != '0));

        cmd_nxt  = CMD_NOP;
        addr_nxt = '0;
        if (state_nxt == S_PRE) begin
            cmd_nxt  = CMD_PRE;
            addr_nxt = ADDR_PRE_ALL;
        end else if (state_nxt == S_AREF) begin
            cmd_nxt  = CMD_AREF;
        end
    end

endmodule

// File: tb/tb_sdram_aref_pend.sv
// Directed bench for sdram_aref_pend: ticks, queueing, single and burst
// refresh sequences, tick/AREF collisions, init abort and reset.
module tb_sdram_aref_pend;

    localparam logic [3:0]  NOP  = 4'b0111;
    localparam logic [3:0]  PRE  = 4'b0010;
    localparam logic [3:0]  AREF = 4'b0001;
    localparam logic [12:0] A10  = 13'h400;

    logic        sclk;
    logic        s_rst;
    logic        flag_init_end;
    logic        ref_en;
    logic        ref_burst;
    logic        ref_req;
    logic        ref_urgent;
    logic        ref_busy;
    logic        flag_ref_end;
    logic [3:0]  aref_cmd;
    logic [12:0] sdram_addr;
    logic [2:0]  pend_cnt;
    logic        pend_ovf;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc_no   = 0;

    sdram_aref_pend #(
        .ADDR_W      (13),
        .REF_INTERVAL(16),
        .T_RP        (2),
        .T_RFC       (7),
        .MAX_PEND    (4),
        .URGENT_TH   (3)
    ) dut (
        .sclk         (sclk),
        .s_rst        (s_rst),
        .flag_init_end(flag_init_end),
        .ref_en       (ref_en),
        .ref_burst    (ref_burst),
        .ref_req      (ref_req),
        .ref_urgent   (ref_urgent),
        .ref_busy     (ref_busy),
        .flag_ref_end (flag_ref_end),
        .aref_cmd     (aref_cmd),
        .sdram_addr   (sdram_addr),
        .pend_cnt     (pend_cnt),
        .pend_ovf     (pend_ovf)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    task automatic goto_cycle(input int c);
        while (cyc_no < c) begin
            @(negedge sclk);
            cyc_no++;
        end
    endtask

    task automatic do_reset();
        s_rst         = 1'b1;
        flag_init_end = 1'b0;
        ref_en        = 1'b0;
        ref_burst     = 1'b0;
        @(negedge sclk);
        @(negedge sclk);
        s_rst = 1'b0;
        @(negedge sclk);
    endtask

    task automatic start_init();
        flag_init_end = 1'b1;
        cyc_no        = 0;
    endtask

    task automatic grant(input int g, input logic burst);
        goto_cycle(g);
        ref_en    = 1'b1;
        ref_burst = burst;
        goto_cycle(g + 1);
        ref_en    = 1'b0;
        ref_burst = 1'b0;
    endtask

    task automatic test_reset();
        s_rst = 1'b1; flag_init_end = 1'b0; ref_en = 1'b0; ref_burst = 1'b0;
        @(negedge sclk);
        @(negedge sclk);
        n_checks++;
        if (aref_cmd !== NOP) $display("FAIL reset_cmd: got %b want %b", aref_cmd, NOP);
        else n_pass++;
        n_checks++;
        if (sdram_addr !== 13'h0) $display("FAIL reset_addr: got %h want 0", sdram_addr);
        else n_pass++;
        n_checks++;
        if ({ref_req, ref_urgent, ref_busy, flag_ref_end, pend_ovf, pend_cnt} !== 8'h0)
            $display("FAIL reset_status: got %b want 0", {ref_req, ref_urgent, ref_busy, flag_ref_end, pend_ovf, pend_cnt});
        else n_pass++;
        s_rst = 1'b0;
        @(negedge sclk);
        n_checks++;
        if (pend_cnt !== 3'd0) $display("FAIL idle_no_init_pend: got %0d want 0", pend_cnt);
        else n_pass++;
    endtask

    task automatic test_ticks();
        do_reset();
        start_init();
        goto_cycle(5);
        ref_en = 1'b1;
        goto_cycle(6);
        ref_en = 1'b0;
        n_checks++;
        if (ref_busy !== 1'b0 || aref_cmd !== NOP)
            $display("FAIL grant_empty_ignored: busy %b cmd %b want 0 %b", ref_busy, aref_cmd, NOP);
        else n_pass++;
        goto_cycle(15);
        n_checks++;
        if (pend_cnt !== 3'd0 || ref_req !== 1'b0)
            $display("FAIL tick_early: pend %0d req %b want 0 0", pend_cnt, ref_req);
        else n_pass++;
        goto_cycle(16);
        n_checks++;
        if (pend_cnt !== 3'd1 || ref_req !== 1'b1)
            $display("FAIL first_tick: pend %0d req %b want 1 1", pend_cnt, ref_req);
        else n_pass++;
        goto_cycle(47);
        n_checks++;
        if (pend_cnt !== 3'd2 || ref_urgent !== 1'b0)
            $display("FAIL pre_urgent: pend %0d urgent %b want 2 0", pend_cnt, ref_urgent);
        else n_pass++;
        goto_cycle(48);
        n_checks++;
        if (pend_cnt !== 3'd3 || ref_urgent !== 1'b1)
            $display("FAIL urgent: pend %0d urgent %b want 3 1", pend_cnt, ref_urgent);
        else n_pass++;
        goto_cycle(64);
        n_checks++;
        if (pend_cnt !== 3'd4 || pend_ovf !== 1'b0)
            $display("FAIL pend_max: pend %0d ovf %b want 4 0", pend_cnt, pend_ovf);
        else n_pass++;
        goto_cycle(80);
        n_checks++;
        if (pend_cnt !== 3'd4 || pend_ovf !== 1'b1)
            $display("FAIL overflow: pend %0d ovf %b want 4 1", pend_cnt, pend_ovf);
        else n_pass++;
        goto_cycle(100);
        n_checks++;
        if (pend_ovf !== 1'b1 || ref_req !== 1'b1)
            $display("FAIL ovf_sticky: ovf %b req %b want 1 1", pend_ovf, ref_req);
        else n_pass++;
    endtask

    // Single AREF from pend_cnt = 1: PRE at 17, AREF at 19, end pulse at 25
    task automatic test_single();
        logic [3:0] exp_cmd;
        do_reset();
        start_init();
        grant(16, 1'b0);
        for (int c = 17; c <= 28; c++) begin
            goto_cycle(c);
            exp_cmd = (c == 17) ? PRE : (c == 19) ? AREF : NOP;
            n_checks++;
            if (aref_cmd !== exp_cmd || sdram_addr !== ((c == 17) ? A10 : 13'h0))
                $display("FAIL single_cmd c%0d: cmd %b addr %h want %b %h", c, aref_cmd, sdram_addr,
                         exp_cmd, (c == 17) ? A10 : 13'h0);
            else n_pass++;
            n_checks++;
            if (flag_ref_end !== (c == 25) || ref_busy !== (c <= 25))
                $display("FAIL single_flags c%0d: end %b busy %b want %b %b", c, flag_ref_end, ref_busy,
                         (c == 25), (c <= 25));
            else n_pass++;
        end
        n_checks++;
        if (pend_cnt !== 3'd0 || ref_req !== 1'b0)
            $display("FAIL single_after: pend %0d req %b want 0 0", pend_cnt, ref_req);
        else n_pass++;
    endtask

    // Single AREF from pend_cnt = 3: one AREF only, queue left at 2
    task automatic test_single_pend3();
        logic [3:0] exp_cmd;
        do_reset();
        start_init();
        grant(48, 1'b0);
        for (int c = 49; c <= 60; c++) begin
            goto_cycle(c);
            exp_cmd = (c == 49) ? PRE : (c == 51) ? AREF : NOP;
            n_checks++;
            if (aref_cmd !== exp_cmd || flag_ref_end !== (c == 57))
                $display("FAIL one_of_three c%0d: cmd %b end %b want %b %b", c, aref_cmd, flag_ref_end,
                         exp_cmd, (c == 57));
            else n_pass++;
        end
        n_checks++;
        if (pend_cnt !== 3'd2 || ref_req !== 1'b1 || ref_busy !== 1'b0)
            $display("FAIL one_of_three_after: pend %0d req %b busy %b want 2 1 0", pend_cnt, ref_req, ref_busy);
        else n_pass++;
    endtask

    // Burst of 3 queued; the tick landing at 64 adds a fourth AREF
    task automatic test_burst();
        logic [3:0] exp_cmd;
        int arefs[4];
        arefs = '{51, 58, 65, 72};
        do_reset();
        start_init();
        grant(48, 1'b1);
        for (int c = 49; c <= 81; c++) begin
            goto_cycle(c);
            exp_cmd = (c == 49) ? PRE : NOP;
            foreach (arefs[i]) if (arefs[i] == c) exp_cmd = AREF;
            n_checks++;
            if (aref_cmd !== exp_cmd || flag_ref_end !== (c == 78) || ref_busy !== (c <= 78))
                $display("FAIL burst c%0d: cmd %b end %b busy %b want %b %b %b", c, aref_cmd, flag_ref_end,
                         ref_busy, exp_cmd, (c == 78), (c <= 78));
            else n_pass++;
            if (c == 64) begin
                n_checks++;
                if (pend_cnt !== 3'd2) $display("FAIL burst_tick_pend: got %0d want 2", pend_cnt);
                else n_pass++;
            end
            if (c == 79) begin
                n_checks++;
                if (pend_cnt !== 3'd0 || ref_req !== 1'b0)
                    $display("FAIL burst_drained: pend %0d req %b want 0 0", pend_cnt, ref_req);
                else n_pass++;
            end
        end
        n_checks++;
        if (pend_cnt !== 3'd1 || ref_req !== 1'b1)
            $display("FAIL burst_next_tick: pend %0d req %b want 1 1", pend_cnt, ref_req);
        else n_pass++;
    endtask

    // Tick coincides with AREF at 63; tick at 80 during WAIT_RFC extends burst
    task automatic test_tick_collide();
        logic [3:0] exp_cmd;
        int arefs[5];
        arefs = '{56, 63, 70, 77, 84};
        do_reset();
        start_init();
        grant(53, 1'b1);
        for (int c = 54; c <= 92; c++) begin
            goto_cycle(c);
            exp_cmd = (c == 54) ? PRE : NOP;
            foreach (arefs[i]) if (arefs[i] == c) exp_cmd = AREF;
            n_checks++;
            if (aref_cmd !== exp_cmd || flag_ref_end !== (c == 90))
                $display("FAIL collide c%0d: cmd %b end %b want %b %b", c, aref_cmd, flag_ref_end,
                         exp_cmd, (c == 90));
            else n_pass++;
            if (c == 63 || c == 64) begin
                n_checks++;
                if (pend_cnt !== 3'd2) $display("FAIL collide_pend c%0d: got %0d want 2", c, pend_cnt);
                else n_pass++;
            end
        end
        n_checks++;
        if (pend_cnt !== 3'd0 || ref_busy !== 1'b0)
            $display("FAIL collide_after: pend %0d busy %b want 0 0", pend_cnt, ref_busy);
        else n_pass++;
    endtask

    // flag_init_end drop in WAIT_RFC: abort, no end pulse, overflow kept
    task automatic test_abort();
        do_reset();
        start_init();
        grant(80, 1'b0);
        goto_cycle(86);
        n_checks++;
        if (ref_busy !== 1'b1 || pend_ovf !== 1'b1)
            $display("FAIL abort_setup: busy %b ovf %b want 1 1", ref_busy, pend_ovf);
        else n_pass++;
        flag_init_end = 1'b0;
        for (int c = 87; c <= 92; c++) begin
            goto_cycle(c);
            n_checks++;
            if (ref_busy !== 1'b0 || aref_cmd !== NOP || pend_cnt !== 3'd0 || flag_ref_end !== 1'b0 ||
                ref_req !== 1'b0 || pend_ovf !== 1'b1)
                $display("FAIL abort c%0d: busy %b cmd %b pend %0d end %b req %b ovf %b want 0 %b 0 0 0 1",
                         c, ref_busy, aref_cmd, pend_cnt, flag_ref_end, ref_req, pend_ovf, NOP);
            else n_pass++;
        end
    endtask

    // s_rst mid-sequence returns every output to its reset value
    task automatic test_reset_mid();
        do_reset();
        start_init();
        grant(80, 1'b1);
        goto_cycle(86);
        s_rst = 1'b1;
        goto_cycle(87);
        n_checks++;
        if (aref_cmd !== NOP || sdram_addr !== 13'h0)
            $display("FAIL rst_mid_cmd: cmd %b addr %h want %b 0", aref_cmd, sdram_addr, NOP);
        else n_pass++;
        n_checks++;
        if ({ref_req, ref_urgent, ref_busy, flag_ref_end, pend_ovf, pend_cnt} !== 8'h0)
            $display("FAIL rst_mid_status: got %b want 0", {ref_req, ref_urgent, ref_busy, flag_ref_end, pend_ovf, pend_cnt});
        else n_pass++;
        s_rst = 1'b0;
        goto_cycle(88);
    endtask

    initial begin
        test_reset();
        test_ticks();
        test_single();
        test_single_pend3();
        test_burst();
        test_tick_collide();
        test_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
